vedm_industries: RTL and testbench

//   Top-level converter tile, instantiated as tt_um_vedm_industries. It takes an
//   8-bit raw power/energy sample from ui_in and applies a fixed x2 conversion gain,

---
 rtl/vedm_pkg.sv | 22 ++
 rtl/vedm_moving_avg.sv | 38 +++
 rtl/vedm_industries.sv | 42 ++++
 tb/tb_vedm_industries.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/vedm_pkg.sv
// Shared widths, conversion constants and the saturating gain function
// for the vedm converter tile.
package vedm_pkg;

   localparam int SAMPLE_W   = 8;
   localparam int SUM_W      = 10;
   localparam int GAIN_SHIFT = 1;
   localparam int AVG_DEPTH  = 4;
   localparam int AVG_SHIFT  = $clog2(AVG_DEPTH);

   // Left-shift by GAIN_SHIFT in a widened word; any bit pushed above
   // SAMPLE_W means overflow and the result clamps to all-ones.
   function automatic logic [SAMPLE_W-1:0] sat_shift(input logic [SAMPLE_W-1:0] sample);
      logic [SAMPLE_W+GAIN_SHIFT-1:0] conv;
      conv = {sample, {GAIN_SHIFT{1'b0}}};
      if (conv[SAMPLE_W+GAIN_SHIFT-1:SAMPLE_W] != '0)
         return '1;
      else
         return conv[SAMPLE_W-1:0];
   endfunction

endpackage

// File: rtl/vedm_moving_avg.sv
// AVG_DEPTH-deep history of converted samples with a running sum;
// the registered average includes the sample arriving on the same edge.
module vedm_moving_avg
   import vedm_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic [SAMPLE_W-1:0] din,
   output logic [SAMPLE_W-1:0] avg
);

   logic [SAMPLE_W-1:0] tap_q [AVG_DEPTH];
   logic [SUM_W-1:0]    sum_q;
   logic [SUM_W-1:0]    sum_d;
   logic [SAMPLE_W-1:0] avg_q;

   // Sum never exceeds AVG_DEPTH*255, so the subtraction cannot underflow.
   always_comb begin
      sum_d = sum_q + {{(SUM_W-SAMPLE_W){1'b0}}, din}
                    - {{(SUM_W-SAMPLE_W){1'b0}}, tap_q[AVG_DEPTH-1]};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < AVG_DEPTH; i++) tap_q[i] <= '0;
         sum_q <= '0;
         avg_q <= '0;
      end else begin
         tap_q[0] <= din;
         for (int i = 1; i < AVG_DEPTH; i++) tap_q[i] <= tap_q[i-1];
         sum_q <= sum_d;
         avg_q <= sum_d[AVG_SHIFT +: SAMPLE_W];
      end
   end

   assign avg = avg_q;

endmodule

// File: rtl/vedm_industries.sv
// Converter tile top: registered saturating x2 gain on uo_out and a
// moving average of the converted value on uio_out.
module vedm_industries
   import vedm_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   logic [SAMPLE_W-1:0] conv_d;
   logic [SAMPLE_W-1:0] conv_q;
   logic [SAMPLE_W-1:0] avg;

   assign conv_d = sat_shift(ui_in);

   always_ff @(posedge clk) begin
      if (!rst_n) conv_q <= '0;
      else        conv_q <= conv_d;
   end

   // Fed from the combinational conversion so taps align with uo_out.
   vedm_moving_avg u_avg (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (conv_d),
      .avg   (avg)
   );

   assign uo_out  = conv_q;
   assign uio_out = avg;
   assign uio_oe  = 8'hFF;

   // Tile-ring inputs the design has no use for.
   wire unused_ok = &{ena, uio_in, 1'b0};

endmodule

// File: tb/tb_vedm_industries.sv
// Directed self-checking bench for the vedm converter tile.
module tb_vedm_industries;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uo_out;
   logic [7:0] uio_in;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int checks = 0;
   int errors = 0;

   vedm_industries dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uo_out  (uo_out),
      .uio_in  (uio_in),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      ui_in = 8'h00;
      step();
      checks++;
      if (uo_out !== 8'h00) begin
         errors++; $display("FAIL reset_uo got %h want 00", uo_out);
      end
      checks++;
      if (uio_out !== 8'h00) begin
         errors++; $display("FAIL reset_uio got %h want 00", uio_out);
      end
      checks++;
      if (uio_oe !== 8'hFF) begin
         errors++; $display("FAIL reset_oe got %h want FF", uio_oe);
      end
      rst_n = 1'b1;
      step();
      checks++;
      if (uo_out !== 8'h00 || uio_out !== 8'h00) begin
         errors++; $display("FAIL release_zero got %h/%h want 00/00", uo_out, uio_out);
      end
   endtask

   task automatic test_ramp(input string tag);
      logic [7:0] exp_avg [5];
      exp_avg = '{8'h0C, 8'h19, 8'h25, 8'h32, 8'h32};
      ui_in = 8'd25;
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if (uo_out !== 8'h32) begin
            errors++; $display("FAIL %s_uo[%0d] got %h want 32", tag, i, uo_out);
         end
         checks++;
         if (uio_out !== exp_avg[i]) begin
            errors++; $display("FAIL %s_avg[%0d] got %h want %h", tag, i, uio_out, exp_avg[i]);
         end
      end
   endtask

   task automatic test_switch();
      logic [7:0] exp_avg [4];
      exp_avg = '{8'h3C, 8'h46, 8'h50, 8'h5A};
      ui_in = 8'd45;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if (uo_out !== 8'h5A) begin
            errors++; $display("FAIL switch_uo[%0d] got %h want 5A", i, uo_out);
         end
         checks++;
         if (uio_out !== exp_avg[i]) begin
            errors++; $display("FAIL switch_avg[%0d] got %h want %h", i, uio_out, exp_avg[i]);
         end
      end
   endtask

   task automatic test_saturation();
      logic [7:0] vin  [7];
      logic [7:0] vexp [7];
      vin  = '{8'd0,  8'd1,  8'd64, 8'd127, 8'd128, 8'd200, 8'd255};
      vexp = '{8'h00, 8'h02, 8'h80, 8'hFE,  8'hFF,  8'hFF,  8'hFF};
      for (int i = 0; i < 7; i++) begin
         ui_in = vin[i];
         step();
         checks++;
         if (uo_out !== vexp[i]) begin
            errors++; $display("FAIL sat_%0d got %h want %h", vin[i], uo_out, vexp[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      ui_in = 8'd255;
      for (int i = 0; i < 4; i++) step();
      checks++;
      if (uio_out !== 8'hFF) begin
         errors++; $display("FAIL full_avg got %h want FF", uio_out);
      end
      rst_n = 1'b0;
      step();
      checks++;
      if (uo_out !== 8'h00 || uio_out !== 8'h00) begin
         errors++; $display("FAIL midreset got %h/%h want 00/00", uo_out, uio_out);
      end
      rst_n = 1'b1;
      step();
      checks++;
      if (uo_out !== 8'hFF) begin
         errors++; $display("FAIL post_reset_uo got %h want FF", uo_out);
      end
      checks++;
      if (uio_out !== 8'h3F) begin
         errors++; $display("FAIL post_reset_avg got %h want 3F", uio_out);
      end
   endtask

   task automatic test_ena();
      ena    = 1'b1;
      uio_in = 8'hA5;
      rst_n  = 1'b0;
      step();
      rst_n  = 1'b1;
      test_ramp("ena1");
      ena    = 1'b0;
      uio_in = 8'hxx;
   endtask

   initial begin
      ena    = 1'b0;
      uio_in = 8'hxx;
      rst_n  = 1'b0;
      ui_in  = 8'h00;
      step();
      test_reset();
      test_ramp("ramp");
      test_switch();
      test_saturation();
      test_reset_mid();
      test_ena();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
